vpu_ovi_issue_queue: RTL and testbench
======================================

Name: vpu_ovi_issue_queue

Overview:
- Credit-managed issue buffer directly upstream of the vector unit (Vpu) on the OVI issue/dispatch interface.
- Accepts vector instructions from core dispatch over a valid/ready handshake and buffers them.
- Drives issue_* to Vpu only while issue credits remain, restoring credits on issue_credit.
- Tracks issued sb_ids in order and converts in-order core resolve events into dispatch_sb_id / dispatch_next_senior / dispatch_kill pulses.

Parameters:
DEPTH, 4, input buffer entries (power of 2, >=2)
CREDITS, 8, issue credits Vpu grants after reset (1..31)
RDEPTH, 16, issued-but-unresolved sb_id tracker entries (power of 2, >=CREDITS)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  core offers instruction
in_ready  out  1  buffer can accept
in_inst  in  32  instruction bits
in_sb_id  in  5  scoreboard id
in_scalar_opnd  in  64  scalar operand
in_vcsr  in  40  vector CSR snapshot
in_vcsr_lmulb2  in  1  extra vlmul bit
issue_valid  out  1  one-cycle issue pulse to Vpu
issue_inst  out  32  to Vpu
issue_sb_id  out  5  to Vpu
issue_scalar_opnd  out  64  to Vpu
issue_vcsr  out  40  to Vpu
issue_vcsr_lmulb2  out  1  to Vpu
issue_credit  in  1  Vpu returns one credit
resolve_valid  in  1  core resolves oldest issued instruction
resolve_kill  in  1  1 = kill, 0 = commit (qualified by resolve_valid)
dispatch_sb_id  out  5  to Vpu
dispatch_next_senior  out  1  to Vpu, one-cycle pulse
dispatch_kill  out  1  to Vpu, one-cycle pulse
credits_avail  out  5  current credit count
err_protocol  out  2  sticky: [0] credit overflow, [1] resolve underflow

Behaviour:
- Reset (reset_n low, async): buffers emptied; credit count = CREDITS; issue_valid, dispatch_next_senior, dispatch_kill = 0; all issue_*/dispatch_sb_id data = 0; err_protocol = 0. in_ready = 0 while reset_n low, 1 from first cycle after release. Reset mid-operation discards all buffered and tracked entries; no pulses emitted.
- Accept: push on posedge when in_valid & in_ready.
- in_ready = !input_full. It does not depend combinationally on the same-cycle pop, so there is no push into a full buffer even when a pop occurs.
- Issue condition per cycle: input buffer non-empty & credit count > 0 & tracker not full.
- When the condition holds at a posedge: pop the head; register its fields into issue_*; set issue_valid = 1 for exactly that next cycle; push issue_sb_id into the tracker.
- Otherwise issue_valid = 0 and issue_* hold their last values.
- Max one issue per cycle. Latency: accepted at edge t into an empty buffer with credit gives issue_valid high in cycle t+1..t+2. Back-to-back issue every cycle is sustained while credits last.
- Credit count per edge: -1 on issue, +1 on issue_credit, unchanged if both.
- issue_credit with count == CREDITS and no same-cycle issue: count holds, err_protocol[0] set.
- credits_avail = credit count, registered.
- Resolve: resolve_valid at posedge with tracker non-empty pops the oldest sb_id into dispatch_sb_id.
  - Kill: dispatch_kill = resolve_kill.
  - Commit: dispatch_next_senior = !resolve_kill.
  - Pulses last one cycle; dispatch_sb_id holds afterwards.
- resolve_valid with tracker empty (including same cycle as the push of the first entry): ignored, err_protocol[1] set. An entry becomes resolvable the cycle after its issue pulse begins.
- Issue and resolve in the same cycle are independent; the tracker supports simultaneous push/pop, including when full.
- Kill does not flush the input buffer; the core stops offering killed younger instructions itself.
- Pointers are log2(depth)+1 bits and wrap naturally. Full = MSB differ, rest equal.
- err_protocol bits clear only on reset.

Decomposition:
- Package vpu_ovi_pkg:
  - sb_id_t (5b)
  - vcsr_t (40b)
  - OVI_INST_W = 32, OVI_SCALAR_W = 64
  - packed struct ovi_issue_t {inst, sb_id, scalar_opnd, vcsr, vcsr_lmulb2} (142b)
- One sub-module vpu_ovi_fifo (parameterised WIDTH/DEPTH; push/pop/full/empty/head), instantiated twice: input buffer of ovi_issue_t, tracker of sb_id_t.
- Credit counter and output registers live in the top.

Test Plan:
1. Reset, push inst 0x02058057 sb_id 3 scalar 0x1234 -> issue_valid one cycle with identical fields, credits_avail 8->7; issue_credit pulse -> 8.
2. Push 10 instructions, no issue_credit -> exactly 8 issue pulses, credits_avail 0. Then one issue_credit -> 9th issues next cycle, credits_avail returns to 0.
3. Issue and issue_credit in the same cycle at count 5 -> credits_avail stays 5.
4. Issue sb_id 1, 2, 3; resolve kill=0, 1, 0 on consecutive cycles -> dispatch_sb_id 1 senior, 2 kill, 3 senior; one pulse each; no overlap.
5. Exhaust credits, then keep pushing -> after 4 more accepts in_ready = 0 and the 5th in_valid is held unaccepted. issue_credit -> in_ready = 1 within 2 cycles, with no lost or duplicated sb_id.
6. issue_credit at count 8 -> err_protocol = 01. resolve_valid with empty tracker -> err_protocol = 11. Drop reset_n mid-stream -> outputs reset asynchronously, credits_avail = 8, no issue/dispatch pulses after release.

Source files
------------

// File: rtl/vpu_ovi_issue_queue_pkg.sv
// Shared types for the OVI issue path between core dispatch and the vector unit.
// Packs one issued instruction into a single 142-bit record.
package vpu_ovi_pkg;

    localparam int OVI_INST_W   = 32;
    localparam int OVI_SCALAR_W = 64;
    localparam int OVI_SB_W     = 5;
    localparam int OVI_VCSR_W   = 40;

    typedef logic [OVI_SB_W-1:0]   sb_id_t;
    typedef logic [OVI_VCSR_W-1:0] vcsr_t;

    typedef struct packed {
        logic [OVI_INST_W-1:0]   inst;
        sb_id_t                  sb_id;
        logic [OVI_SCALAR_W-1:0] scalar_opnd;
        vcsr_t                   vcsr;
        logic                    vcsr_lmulb2;
    } ovi_issue_t;

endpackage

// File: rtl/vpu_ovi_issue_queue_fifo.sv
// Synchronous FIFO with extra-MSB pointers; accepts push while full only when a
// same-cycle pop frees the slot being overwritten.
module vpu_ovi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Pointer update, wrapping naturally through the extra MSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vpu_ovi_issue_queue.sv
// Credit-managed OVI issue buffer: buffers dispatched vector instructions, issues
// them while Vpu credits remain, and turns in-order resolves into dispatch pulses.
module vpu_ovi_issue_queue
    import vpu_ovi_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 8,
    parameter int RDEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [4:0]  in_sb_id,
    input  logic [63:0] in_scalar_opnd,
    input  logic [39:0] in_vcsr,
    input  logic        in_vcsr_lmulb2,
    output logic        issue_valid,
    output logic [31:0] issue_inst,
    output logic [4:0]  issue_sb_id,
    output logic [63:0] issue_scalar_opnd,
    output logic [39:0] issue_vcsr,
    output logic        issue_vcsr_lmulb2,
    input  logic        issue_credit,
    input  logic        resolve_valid,
    input  logic        resolve_kill,
    output logic [4:0]  dispatch_sb_id,
    output logic        dispatch_next_senior,
    output logic        dispatch_kill,
    output logic [4:0]  credits_avail,
    output logic [1:0]  err_protocol
);

    localparam logic [4:0] L_CREDITS = 5'(CREDITS);

    logic       r_alive;
    logic [4:0] r_credits;
    logic       r_issue_valid;
    ovi_issue_t r_issue;
    sb_id_t     r_disp_sb;
    logic       r_senior;
    logic       r_kill;
    logic [1:0] r_err;

    ovi_issue_t w_in_data;
    ovi_issue_t w_in_head;
    logic       w_in_full;
    logic       w_in_empty;
    sb_id_t     w_trk_head;
    logic       w_trk_full;
    logic       w_trk_empty;
    logic       w_issue;
    logic       w_resolve;
    logic       w_credit_ovf;
    logic [4:0] w_credits_nxt;

    assign w_in_data    = '{inst: in_inst, sb_id: in_sb_id, scalar_opnd: in_scalar_opnd,
                            vcsr: in_vcsr, vcsr_lmulb2: in_vcsr_lmulb2};
    // r_alive holds in_ready low through reset and until the first clock after it.
    assign in_ready     = r_alive & ~w_in_full;
    assign w_issue      = ~w_in_empty & (r_credits != 5'd0) & ~w_trk_full;
    assign w_resolve    = resolve_valid & ~w_trk_empty;
    assign w_credit_ovf = issue_credit & ~w_issue & (r_credits == L_CREDITS);

    vpu_ovi_fifo #(.WIDTH($bits(ovi_issue_t)), .DEPTH(DEPTH)) u_in_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (in_valid & in_ready),
        .push_data (w_in_data),
        .pop       (w_issue),
        .full      (w_in_full),
        .empty     (w_in_empty),
        .head      (w_in_head)
    );

    vpu_ovi_fifo #(.WIDTH($bits(sb_id_t)), .DEPTH(RDEPTH)) u_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_issue),
        .push_data (w_in_head.sb_id),
        .pop       (w_resolve),
        .full      (w_trk_full),
        .empty     (w_trk_empty),
        .head      (w_trk_head)
    );

    // Next credit count: issue consumes, issue_credit restores, both cancel.
    always_comb begin
        w_credits_nxt = r_credits;
        case ({w_issue, issue_credit})
            2'b10:   w_credits_nxt = r_credits - 5'd1;
            2'b01:   w_credits_nxt = w_credit_ovf ? r_credits : r_credits + 5'd1;
            default: w_credits_nxt = r_credits;
        endcase
    end

    // Credit counter, issue/dispatch output registers and sticky protocol errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alive       <= 1'b0;
            r_credits     <= L_CREDITS;
            r_issue_valid <= 1'b0;
            r_issue       <= '0;
            r_disp_sb     <= '0;
            r_senior      <= 1'b0;
            r_kill        <= 1'b0;
            r_err         <= 2'b00;
        end else begin
            r_alive       <= 1'b1;
            r_credits     <= w_credits_nxt;
            r_issue_valid <= w_issue;
            if (w_issue) r_issue <= w_in_head;
            r_senior      <= w_resolve & ~resolve_kill;
            r_kill        <= w_resolve & resolve_kill;
            if (w_resolve) r_disp_sb <= w_trk_head;
            r_err         <= r_err | {resolve_valid & w_trk_empty, w_credit_ovf};
        end
    end

    assign issue_valid          = r_issue_valid;
    assign issue_inst           = r_issue.inst;
    assign issue_sb_id          = r_issue.sb_id;
    assign issue_scalar_opnd    = r_issue.scalar_opnd;
    assign issue_vcsr           = r_issue.vcsr;
    assign issue_vcsr_lmulb2    = r_issue.vcsr_lmulb2;
    assign dispatch_sb_id       = r_disp_sb;
    assign dispatch_next_senior = r_senior;
    assign dispatch_kill        = r_kill;
    assign credits_avail        = r_credits;
    assign err_protocol         = r_err;

endmodule

// File: tb/tb_vpu_ovi_issue_queue.sv
// Self-checking bench for vpu_ovi_issue_queue: scoreboards for issue and dispatch,
// a resolve vector table, and directed credit/backpressure/reset sequences.
module tb_vpu_ovi_issue_queue;
    import vpu_ovi_pkg::*;

    logic        clk, reset_n;
    logic        in_valid, in_ready;
    logic [31:0] in_inst;
    logic [4:0]  in_sb_id;
    logic [63:0] in_scalar_opnd;
    logic [39:0] in_vcsr;
    logic        in_vcsr_lmulb2;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic [4:0]  issue_sb_id;
    logic [63:0] issue_scalar_opnd;
    logic [39:0] issue_vcsr;
    logic        issue_vcsr_lmulb2;
    logic        issue_credit, resolve_valid, resolve_kill;
    logic [4:0]  dispatch_sb_id;
    logic        dispatch_next_senior, dispatch_kill;
    logic [4:0]  credits_avail;
    logic [1:0]  err_protocol;

    vpu_ovi_issue_queue #(.DEPTH(4), .CREDITS(8), .RDEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_sb_id(in_sb_id),
        .in_scalar_opnd(in_scalar_opnd), .in_vcsr(in_vcsr), .in_vcsr_lmulb2(in_vcsr_lmulb2),
        .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_sb_id(issue_sb_id),
        .issue_scalar_opnd(issue_scalar_opnd), .issue_vcsr(issue_vcsr),
        .issue_vcsr_lmulb2(issue_vcsr_lmulb2), .issue_credit(issue_credit),
        .resolve_valid(resolve_valid), .resolve_kill(resolve_kill),
        .dispatch_sb_id(dispatch_sb_id), .dispatch_next_senior(dispatch_next_senior),
        .dispatch_kill(dispatch_kill), .credits_avail(credits_avail), .err_protocol(err_protocol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] sb;
        logic       kill;
        logic       exp_senior;
        logic       exp_kill;
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_issue  = 0;
    int         owed     = 0;
    int         seq      = 100;
    int         base;
    ovi_issue_t exp_q[$];
    sb_id_t     trk_q[$];
    logic [5:0] dexp_q[$];
    ovi_issue_t m_e;
    logic [5:0] m_d;
    vec_t       tbl[3];
    ovi_issue_t it;
    bit         found;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ovi_issue_t mk(input int s);
        ovi_issue_t r;
        r.inst        = 32'h0205_8057 ^ (32'(s) << 8);
        r.sb_id       = 5'(s);
        r.scalar_opnd = {32'(s) ^ 32'hDEAD_0000, 32'h0000_1000 + 32'(s)};
        r.vcsr        = 40'h12_0000_0000 | 40'(s * 7);
        r.vcsr_lmulb2 = 1'(s & 1);
        return r;
    endfunction

    // Issue and dispatch scoreboards, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (issue_valid) begin
                n_issue++;
                owed++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL issue_unexpected: got sb_id %0d expected none", issue_sb_id);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("issue_fields", 160'({issue_inst, issue_sb_id, issue_scalar_opnd,
                        issue_vcsr, issue_vcsr_lmulb2}), 160'(m_e));
                    trk_q.push_back(m_e.sb_id);
                end
            end
            if (dispatch_next_senior || dispatch_kill) begin
                chk("dispatch_overlap", 160'(dispatch_next_senior & dispatch_kill), 160'(0));
                if (dexp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL dispatch_unexpected: got sb_id %0d expected none", dispatch_sb_id);
                end else begin
                    m_d = dexp_q.pop_front();
                    chk("dispatch_fields", 160'({dispatch_sb_id, dispatch_kill}), 160'(m_d));
                end
            end
        end
    end

    task automatic send(input ovi_issue_t x);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_inst = x.inst; in_sb_id = x.sb_id; in_scalar_opnd = x.scalar_opnd;
        in_vcsr = x.vcsr; in_vcsr_lmulb2 = x.vcsr_lmulb2;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(x);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("send_accepted", 160'(done), 160'(1));
    endtask

    task automatic credit_one();
        issue_credit = 1'b1;
        owed--;
        tick();
        issue_credit = 1'b0;
    endtask

    task automatic resolve_one(input logic kill);
        resolve_valid = 1'b1;
        resolve_kill  = kill;
        if (trk_q.size() > 0) dexp_q.push_back({trk_q.pop_front(), kill});
        tick();
        resolve_valid = 1'b0;
        resolve_kill  = 1'b0;
    endtask

    task automatic wait_issues(input int target, input string name);
        for (int k = 0; k < 40 && n_issue < target; k++) tick();
        chk(name, 160'(n_issue), 160'(target));
    endtask

    // Return every outstanding credit and resolve every tracked sb_id as commit.
    task automatic drain();
        for (int k = 0; k < 100 && (owed > 0 || trk_q.size() > 0 || exp_q.size() > 0); k++) begin
            issue_credit = (owed > 0);
            if (owed > 0) owed--;
            resolve_valid = (trk_q.size() > 0);
            resolve_kill  = 1'b0;
            if (trk_q.size() > 0) dexp_q.push_back({trk_q.pop_front(), 1'b0});
            tick();
            issue_credit  = 1'b0;
            resolve_valid = 1'b0;
        end
        tick(); tick();
        chk("drain_done", 160'(exp_q.size() + trk_q.size() + dexp_q.size()), 160'(0));
        chk("drain_credits", 160'(credits_avail), 160'(8));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{5'd1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{5'd2, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{5'd3, 1'b0, 1'b1, 1'b0};

        reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_sb_id = '0; in_scalar_opnd = '0;
        in_vcsr = '0; in_vcsr_lmulb2 = 1'b0; issue_credit = 1'b0;
        resolve_valid = 1'b0; resolve_kill = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", 160'(in_ready), 160'(0));
        chk("rst_issue_valid", 160'(issue_valid), 160'(0));
        chk("rst_credits", 160'(credits_avail), 160'(8));
        chk("rst_err", 160'(err_protocol), 160'(0));
        chk("rst_dispatch", 160'({dispatch_sb_id, dispatch_next_senior, dispatch_kill}), 160'(0));
        chk("rst_issue_data", 160'({issue_inst, issue_sb_id, issue_scalar_opnd}), 160'(0));
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 160'(in_ready), 160'(1));

        // Single instruction round trip with credit return and commit.
        it = '{inst: 32'h0205_8057, sb_id: 5'd3, scalar_opnd: 64'h1234, vcsr: 40'h0, vcsr_lmulb2: 1'b0};
        send(it);
        wait_issues(1, "t1_issue");
        chk("t1_credits7", 160'(credits_avail), 160'(7));
        chk("t1_pulse_one_cycle", 160'(issue_valid), 160'(0));
        chk("t1_sb_hold", 160'(issue_sb_id), 160'(3));
        credit_one();
        chk("t1_credits8", 160'(credits_avail), 160'(8));
        resolve_one(1'b0);
        chk("t1_disp_sb", 160'(dispatch_sb_id), 160'(3));
        chk("t1_senior", 160'(dispatch_next_senior), 160'(1));
        tick();
        chk("t1_senior_off", 160'(dispatch_next_senior), 160'(0));

        // Issue and credit return on the same edge at count 5.
        base = n_issue;
        for (int i = 0; i < 3; i++) begin send(mk(seq)); seq++; end
        wait_issues(base + 3, "t3_three_issues");
        chk("t3_credits5", 160'(credits_avail), 160'(5));
        send(mk(seq)); seq++;
        issue_credit = 1'b1;
        owed--;
        tick();
        issue_credit = 1'b0;
        chk("t3_credits_hold", 160'(credits_avail), 160'(5));
        tick();
        chk("t3_issue_seen", 160'(n_issue), 160'(base + 4));
        chk("t3_credits_still5", 160'(credits_avail), 160'(5));
        drain();

        // Resolve table: commit, kill, commit on consecutive cycles.
        base = n_issue;
        for (int i = 0; i < 3; i++) begin
            it = mk(seq); seq++;
            it.sb_id = tbl[i].sb;
            send(it);
        end
        wait_issues(base + 3, "t4_issues");
        tick();
        for (int i = 0; i < 3; i++) begin
            resolve_one(tbl[i].kill);
            chk("t4_sb", 160'(dispatch_sb_id), 160'(tbl[i].sb));
            chk("t4_senior", 160'(dispatch_next_senior), 160'(tbl[i].exp_senior));
            chk("t4_kill", 160'(dispatch_kill), 160'(tbl[i].exp_kill));
        end
        tick();
        chk("t4_pulses_off", 160'({dispatch_next_senior, dispatch_kill}), 160'(0));
        chk("t4_sb_hold", 160'(dispatch_sb_id), 160'(3));
        drain();

        // Ten pushes against eight credits.
        base = n_issue;
        for (int i = 0; i < 10; i++) begin send(mk(seq)); seq++; end
        repeat (6) tick();
        chk("t2_eight_issues", 160'(n_issue), 160'(base + 8));
        chk("t2_credits0", 160'(credits_avail), 160'(0));
        credit_one();
        wait_issues(base + 9, "t2_ninth_issue");
        tick();
        chk("t2_credits0_again", 160'(credits_avail), 160'(0));
        credit_one();
        wait_issues(base + 10, "t2_tenth_issue");
        for (int i = 0; i < 10; i++) resolve_one(1'(i % 3 == 0));
        tick();

        // Backpressure with no credits: four accepts fill the buffer.
        for (int i = 0; i < 4; i++) begin send(mk(seq)); seq++; end
        chk("t5_full_ready", 160'(in_ready), 160'(0));
        it = mk(seq); seq++;
        in_valid = 1'b1; in_inst = it.inst; in_sb_id = it.sb_id; in_scalar_opnd = it.scalar_opnd;
        in_vcsr = it.vcsr; in_vcsr_lmulb2 = it.vcsr_lmulb2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_held", 160'(in_ready), 160'(0));
            tick();
        end
        credit_one();
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            @(negedge clk);
            if (in_ready) begin exp_q.push_back(it); found = 1'b1; end
            tick();
        end
        in_valid = 1'b0;
        chk("t5_ready_after_credit", 160'(found), 160'(1));
        drain();

        // Protocol errors are sticky.
        issue_credit = 1'b1;
        tick();
        issue_credit = 1'b0;
        chk("t6_err_credit", 160'(err_protocol), 160'(2'b01));
        chk("t6_credits_cap", 160'(credits_avail), 160'(8));
        resolve_valid = 1'b1;
        tick();
        resolve_valid = 1'b0;
        chk("t6_err_resolve", 160'(err_protocol), 160'(2'b11));
        tick();
        chk("t6_err_sticky", 160'(err_protocol), 160'(2'b11));

        // Asynchronous reset in the middle of traffic.
        send(mk(seq)); seq++;
        send(mk(seq)); seq++;
        resolve_valid = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        resolve_valid = 1'b0;
        exp_q.delete(); trk_q.delete(); dexp_q.delete();
        owed = 0;
        base = n_issue;
        chk("t6_rst_issue_valid", 160'(issue_valid), 160'(0));
        chk("t6_rst_credits", 160'(credits_avail), 160'(8));
        chk("t6_rst_err", 160'(err_protocol), 160'(0));
        chk("t6_rst_in_ready", 160'(in_ready), 160'(0));
        chk("t6_rst_dispatch", 160'({dispatch_sb_id, dispatch_next_senior, dispatch_kill}), 160'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) tick();
        chk("t6_no_issue_after", 160'(n_issue), 160'(base));
        chk("t6_credits_after", 160'(credits_avail), 160'(8));
        chk("t6_ready_after", 160'(in_ready), 160'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
